// File: rtl/ddr2_chk_pkg.sv
// Shared types and constants for the DDR2 read-data checker: FSM encoding,
// pattern seed and default widths.
package ddr2_chk_pkg;

    typedef enum logic [1:0] {
        WAIT_INIT = 2'd0,
        CHECK     = 2'd1,
        FAIL      = 2'd2
    } chk_state_t;

    localparam int PATTERN_SEED   = 1;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LEN_WIDTH  = 8;
    localparam int DEF_CNT_WIDTH  = 16;
    localparam int DEF_HB_BITS    = 24;

endpackage

// File: rtl/ddr2_rd_checker_if.sv
// Read-beat stream from axi_rd_master to the checker; master drives, the
// checker listens on the slave modport.
interface ddr2_rd_checker_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
);
    logic [LEN_WIDTH-1:0]  rd_len;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_data_en;
    logic                  rd_done;

    modport master (
        output rd_len,
        output rd_data,
        output rd_data_en,
        output rd_done
    );

    modport slave (
        input rd_len,
        input rd_data,
        input rd_data_en,
        input rd_done
    );
endinterface

// File: rtl/ddr2_led_blink.sv
// Heartbeat divider: free-running HB_BITS counter that flips tgl each time it
// wraps while enabled.
module ddr2_led_blink #(
    parameter int HB_BITS = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tgl
);
    logic [HB_BITS-1:0] div_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            tgl   <= 1'b0;
        end else if (en) begin
            div_q <= div_q + HB_BITS'(1);
            if (&div_q)
                tgl <= ~tgl;
        end
    end
endmodule

// File: rtl/ddr2_rd_checker.sv
// Read-data checker: compares each beat with an incrementing pattern, checks
// burst lengths, counts beats/bursts/errors and drives a pass/fail LED.
// Optional mismatch capture ports are built when DDR2_CHK_CAPTURE_EN is defined.
module ddr2_rd_checker
    import ddr2_chk_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int HB_BITS    = DEF_HB_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init_end,
    ddr2_rd_checker_if.slave     rd,
    input  logic                 err_clr,
    output logic                 led,
    output logic                 err_flag,
    output logic [CNT_WIDTH-1:0] err_cnt,
    output logic [CNT_WIDTH-1:0] beat_cnt,
    output logic [CNT_WIDTH-1:0] burst_cnt
`ifdef DDR2_CHK_CAPTURE_EN
    ,
    output logic [DATA_WIDTH-1:0] err_data,
    output logic [DATA_WIDTH-1:0] err_exp,
    output logic [CNT_WIDTH-1:0]  err_beat
`endif
);
    localparam int BB_W = LEN_WIDTH + 1;

    chk_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] exp_q;
    logic [BB_W-1:0]       bb_q, bb_inc;
    logic [LEN_WIDTH-1:0]  len_q, len_eff;
    logic                  active, clr, data_err, len_err, err_evt;
    logic [1:0]            err_inc;
    logic [CNT_WIDTH-1:0]  err_base, beat_base, burst_base;
    logic                  hb_tgl;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [1:0] b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + {{(CNT_WIDTH-1){1'b0}}, b};
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    // A burst with no beats yet takes its length straight from the port.
    always_comb begin
        active     = (state_q != WAIT_INIT) && init_end;
        clr        = active && err_clr;
        bb_inc     = bb_q + BB_W'(rd.rd_data_en);
        len_eff    = (bb_q == '0) ? rd.rd_len : len_q;
        data_err   = active && rd.rd_data_en && (rd.rd_data != exp_q);
        len_err    = active && rd.rd_done && (bb_inc != {1'b0, len_eff});
        err_evt    = data_err || len_err;
        err_inc    = {1'b0, data_err} + {1'b0, len_err};
        err_base   = clr ? '0 : err_cnt;
        beat_base  = clr ? '0 : beat_cnt;
        burst_base = clr ? '0 : burst_cnt;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_INIT: if (init_end) state_d = CHECK;
            CHECK, FAIL: begin
                if (!init_end)    state_d = WAIT_INIT;
                else if (err_evt) state_d = FAIL;
                else if (clr)     state_d = CHECK;
            end
            default:              state_d = WAIT_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= WAIT_INIT;
        else        state_q <= state_d;
    end

    // Pattern tracker and counters; everything snaps back to seed while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q     <= DATA_WIDTH'(PATTERN_SEED);
            bb_q      <= '0;
            len_q     <= '0;
            err_flag  <= 1'b0;
            err_cnt   <= '0;
            beat_cnt  <= '0;
            burst_cnt <= '0;
        end else if (!active) begin
            exp_q     <= DATA_WIDTH'(PATTERN_SEED);
            bb_q      <= '0;
            len_q     <= '0;
            err_flag  <= 1'b0;
            err_cnt   <= '0;
            beat_cnt  <= '0;
            burst_cnt <= '0;
        end else begin
            if (rd.rd_data_en)
                exp_q <= exp_q + DATA_WIDTH'(1);
            if (rd.rd_data_en && (bb_q == '0))
                len_q <= rd.rd_len;
            bb_q      <= rd.rd_done ? '0 : bb_inc;
            beat_cnt  <= beat_base + CNT_WIDTH'(rd.rd_data_en);
            burst_cnt <= burst_base + CNT_WIDTH'(rd.rd_done);
            err_cnt   <= sat_add(err_base, err_inc);
            err_flag  <= (err_flag && !clr) || err_evt;
        end
    end

    ddr2_led_blink #(.HB_BITS(HB_BITS)) u_blink (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == CHECK),
        .tgl   (hb_tgl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= 1'b0;
        end else begin
            unique case (state_d)
                FAIL:    led <= 1'b1;
                CHECK:   led <= hb_tgl;
                default: led <= 1'b0;
            endcase
        end
    end

`ifdef DDR2_CHK_CAPTURE_EN
    logic cap_vld;

    // Freeze on the first error; err_clr re-arms, and an error in the same
    // cycle as err_clr is captured at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_vld  <= 1'b0;
            err_data <= '0;
            err_exp  <= '0;
            err_beat <= '0;
        end else if (!active) begin
            cap_vld  <= 1'b0;
        end else if (err_evt && (clr || !cap_vld)) begin
            cap_vld  <= 1'b1;
            err_beat <= beat_base;
            if (data_err) begin
                err_data <= rd.rd_data;
                err_exp  <= exp_q;
            end else begin
                err_data <= '0;
                err_exp  <= DATA_WIDTH'(len_eff);
            end
        end else if (clr) begin
            cap_vld  <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_ddr2_rd_checker.sv
// Directed bench for ddr2_rd_checker with a per-cycle scoreboard of expected
// register outputs; narrow data width so the pattern wrap is reachable.
module tb_ddr2_rd_checker;
    import ddr2_chk_pkg::*;

    localparam int DW = 8;
    localparam int LW = 8;
    localparam int CW = 16;
    localparam int HB = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_end = 1'b0;
    logic          err_clr = 1'b0;
    logic          led, err_flag;
    logic [CW-1:0] err_cnt, beat_cnt, burst_cnt;
`ifdef DDR2_CHK_CAPTURE_EN
    logic [DW-1:0] err_data, err_exp;
    logic [CW-1:0] err_beat;
`endif

    ddr2_rd_checker_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) rd_if ();

    always #5 clk = ~clk;

    ddr2_rd_checker #(
        .DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW), .HB_BITS(HB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_end  (init_end),
        .rd        (rd_if),
        .err_clr   (err_clr),
        .led       (led),
        .err_flag  (err_flag),
        .err_cnt   (err_cnt),
        .beat_cnt  (beat_cnt),
        .burst_cnt (burst_cnt)
`ifdef DDR2_CHK_CAPTURE_EN
        ,
        .err_data  (err_data),
        .err_exp   (err_exp),
        .err_beat  (err_beat)
`endif
    );

    typedef struct packed {
        logic          flag;
        logic [CW-1:0] ecnt;
        logic [CW-1:0] bcnt;
        logic [CW-1:0] brst;
        logic          led_chk;
        logic          led_v;
        logic [1:0]    st;
    } exp_t;

    exp_t          sbq[$];
    int            errors = 0;
    int            checks = 0;
    int            toggles = 0;
    logic          led_prev = 1'b0;
    logic          ie_req = 1'b0;

    int            m_st, m_bb, m_len;
    logic [DW-1:0] m_exp;
    logic [CW-1:0] m_err, m_beat, m_burst;
    logic          m_flag;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_bb = 0; m_len = 0; m_exp = DW'(1);
        m_err = '0; m_beat = '0; m_burst = '0; m_flag = 1'b0;
    endtask

    task automatic model(input bit en, input int d, input bit done, input int len, input bit clr);
        int bad;
        bad = 0;
        if (m_st == 0) begin
            if (ie_req) m_st = 1;
        end else if (!ie_req) begin
            model_reset();
        end else begin
            if (clr) begin
                m_err = '0; m_beat = '0; m_burst = '0; m_flag = 1'b0;
                if (m_st == 2) m_st = 1;
            end
            if (en) begin
                if (m_bb == 0) m_len = len;
                if (DW'(d) !== m_exp) bad++;
                m_exp++; m_beat++; m_bb++;
            end
            if (done) begin
                if (m_bb == 0) m_len = len;
                if (m_bb != m_len) bad++;
                m_burst++; m_bb = 0;
            end
            if (bad > 0) begin
                m_flag = 1'b1;
                m_st = 2;
                if (int'(m_err) + bad > 65535) m_err = '1;
                else m_err = m_err + CW'(bad);
            end
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("err_flag", 32'(err_flag), 32'(e.flag));
            chk("err_cnt", 32'(err_cnt), 32'(e.ecnt));
            chk("beat_cnt", 32'(beat_cnt), 32'(e.bcnt));
            chk("burst_cnt", 32'(burst_cnt), 32'(e.brst));
            chk("state", 32'(dut.state_q), 32'(e.st));
            if (e.led_chk) chk("led", 32'(led), 32'(e.led_v));
        end
        if (led !== led_prev) toggles++;
        led_prev = led;
    endtask

    task automatic cyc(input bit en, input int d, input bit done, input int len, input bit clr);
        exp_t e;
        @(negedge clk);
        check_out();
        init_end         = ie_req;
        rd_if.rd_data_en = en;
        rd_if.rd_data    = DW'(d);
        rd_if.rd_done    = done;
        rd_if.rd_len     = LW'(len);
        err_clr          = clr;
        model(en, d, done, len, clr);
        e.flag    = m_flag;
        e.ecnt    = m_err;
        e.bcnt    = m_beat;
        e.brst    = m_burst;
        e.led_chk = (m_st != 1);
        e.led_v   = (m_st == 2);
        e.st      = 2'(m_st);
        sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic burst(input int start, input int n, input int len, input int bad_idx, input int bad_val);
        for (int i = 0; i < n; i++)
            cyc(1'b1, (i == bad_idx) ? bad_val : start + i, i == n - 1, len, 1'b0);
    endtask

    initial begin
        rd_if.rd_data_en = 1'b0;
        rd_if.rd_data    = '0;
        rd_if.rd_done    = 1'b0;
        rd_if.rd_len     = '0;
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_err_flag", 32'(err_flag), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        chk("rst_burst_cnt", 32'(burst_cnt), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(WAIT_INIT));
        rst_n = 1'b1;

        // Clean run: 4 bursts of 32, data 1..128
        idle(2);
        ie_req = 1'b1;
        idle(1);
        toggles = 0;
        for (int b = 0; b < 4; b++) burst(1 + 32 * b, 32, 32, -1, 0);
        idle(1);
        chk("clean_beat_cnt", 32'(beat_cnt), 32'd128);
        chk("clean_burst_cnt", 32'(burst_cnt), 32'd4);
        chk("clean_err_cnt", 32'(err_cnt), 32'd0);
        chk("clean_err_flag", 32'(err_flag), 32'd0);
        chk("led_toggling", 32'(toggles >= 4), 32'd1);

        // Walk the pattern up to the top and across the wrap
        burst(129, 125, 125, -1, 0);
        burst(8'hFE, 4, 4, -1, 0);
        idle(1);
        chk("wrap_err_flag", 32'(err_flag), 32'd0);
        chk("wrap_err_cnt", 32'(err_cnt), 32'd0);
        chk("wrap_beat_cnt", 32'(beat_cnt), 32'd257);

        // Drop init_end mid-burst
        for (int i = 0; i < 10; i++) cyc(1'b1, 2 + i, 1'b0, 32, 1'b0);
        ie_req = 1'b0;
        idle(2);
        chk("drop_led", 32'(led), 32'd0);
        chk("drop_beat_cnt", 32'(beat_cnt), 32'd0);
        chk("drop_burst_cnt", 32'(burst_cnt), 32'd0);
        chk("drop_state", 32'(dut.state_q), 32'(WAIT_INIT));
        ie_req = 1'b1;
        idle(1);
        burst(1, 32, 32, -1, 0);
        idle(1);
        chk("reinit_err_cnt", 32'(err_cnt), 32'd0);
        chk("reinit_beat_cnt", 32'(beat_cnt), 32'd32);

        // Beat 40 carries 0x27 instead of 0x28
        burst(33, 32, 32, 7, 8'h27);
        idle(1);
        chk("bad_err_flag", 32'(err_flag), 32'd1);
        chk("bad_err_cnt", 32'(err_cnt), 32'd1);
        chk("bad_led", 32'(led), 32'd1);
        chk("bad_state", 32'(dut.state_q), 32'(FAIL));
`ifdef DDR2_CHK_CAPTURE_EN
        chk("cap_data", 32'(err_data), 32'h27);
        chk("cap_exp", 32'(err_exp), 32'h28);
        chk("cap_beat", 32'(err_beat), 32'd39);
`endif

        // err_clr alone, then a bad beat, then err_clr with a bad beat
        cyc(1'b0, 0, 1'b0, 0, 1'b1);
        idle(1);
        chk("clr_err_cnt", 32'(err_cnt), 32'd0);
        chk("clr_err_flag", 32'(err_flag), 32'd0);
        chk("clr_state", 32'(dut.state_q), 32'(CHECK));
        cyc(1'b1, 0, 1'b1, 1, 1'b0);
        cyc(1'b1, 0, 1'b1, 1, 1'b1);
        idle(1);
        chk("clrbad_err_cnt", 32'(err_cnt), 32'd1);
        chk("clrbad_beat_cnt", 32'(beat_cnt), 32'd1);
        chk("clrbad_state", 32'(dut.state_q), 32'(FAIL));

        // Short burst: 31 beats against rd_len 32
        cyc(1'b0, 0, 1'b0, 0, 1'b1);
        burst(67, 31, 32, -1, 0);
        idle(1);
        chk("len_err_cnt", 32'(err_cnt), 32'd1);
        chk("len_burst_cnt", 32'(burst_cnt), 32'd1);
        chk("len_state", 32'(dut.state_q), 32'(FAIL));
        burst(98, 1, 1, -1, 0);
        idle(1);
        chk("len_exp_advanced", 32'(err_cnt), 32'd1);

        idle(2);
        @(negedge clk);
        check_out();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
